// File: rtl/polarity_lane_arbiter.sv
// polarity_lane_arbiter: round-robin arbiter that shares one lane array
// among NREQ requesters. Each lane is a buffer or an inverter. The winner's
// word passes through the lanes into a registered valid/ready output slot.
// Optional build macro: PLA_RUNTIME_MASK_EN. It adds the cfg_load and
// cfg_mask ports and a mask register that can be loaded while IDLE.

// Single polarity lane: fixed buffer or inverter chosen at elaboration.
module pla_lane #(
    parameter bit INVERT = 1'b0
) (
    input  logic lane_in,
    output logic lane_out
);
    generate
        if (INVERT) begin : g_inv
            assign lane_out = ~lane_in;
        end else begin : g_buf
            assign lane_out = lane_in;
        end
    endgenerate
endmodule

module polarity_lane_arbiter #(
    parameter int              NREQ        = 4,
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] INVERT_MASK = 4'b1010,
    localparam int             SRCW        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRCW-1:0]       out_src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
`ifdef PLA_RUNTIME_MASK_EN
    ,
    input  logic                  cfg_load,
    input  logic [WIDTH-1:0]      cfg_mask
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SRCW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SRCW-1:0]   out_src_q, out_src_d;

    logic [SRCW-1:0]   winner;
    logic              any_valid;
    logic              can_load;
    logic              fire;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  lane_out;

    // Find the first valid requester at or after rr_ptr. The search wraps from NREQ-1 to 0.
    always_comb begin
        // NOTE: every variable gets a default before any branch. A path that
        // leaves a combinational output unassigned would infer a latch.
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_valid && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                any_valid = 1'b1;
                winner    = SRCW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    // The slot can load when it is empty or when it is being drained this cycle. Reset blocks grants.
    assign can_load = (state_q == IDLE) || out_ready;
    assign fire     = any_valid && can_load && !rst;

    // One-hot grant to the winner, raised only when the word is actually taken.
    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Steer the winning requester's word into the lane array.
    always_comb begin
        sel_data = req_data[winner*WIDTH +: WIDTH];
    end

`ifdef PLA_RUNTIME_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    // A mask update is accepted only while IDLE, so a stream never changes polarity partway through.
    always_comb begin
        mask_d = mask_q;
        if (cfg_load && (state_q == IDLE)) begin
            mask_d = cfg_mask;
        end
    end

    // Mask register, reset to the elaboration-time polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= INVERT_MASK;
        end else begin
            mask_q <= mask_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign lane_out[i] = sel_data[i] ^ mask_q[i];
    end
`else
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pla_lane #(
            .INVERT (INVERT_MASK[i])
        ) u_lane (
            .lane_in  (sel_data[i]),
            .lane_out (lane_out[i])
        );
    end
`endif

    // FSM next state, output slot load and round-robin pointer advance.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (fire) begin
            out_data_d = lane_out;
            out_src_d  = winner;
            rr_ptr_d   = (winner == SRCW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output-slot registers. Reset takes effect immediately and discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All flops
            // then sample their pre-edge values, and the order of the
            // statements does not matter.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);

endmodule
